serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder for the adder test environment. It takes two WIDTH-bit operands plus a carry-in on a single-cycle start strobe. It then adds them LSB-first, one bit per clock, through a single existing `fulladdbhav` full-adder cell, and presents a registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits directly in front of the `fulladdbhav` cell and drives its a/b/cin inputs each cycle, so one full-adder serves any operand width.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally
- start  input  1  request strobe; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse when sum/cout are updated
- sum  output  WIDTH  result register; holds the last completed result
- cout  output  1  final carry of the last completed addition

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, acc<=0
  - next state SHIFT
- IDLE, start=0: remain in IDLE.
- SHIFT, every cycle:
  - drive the full adder with a_sh[0], b_sh[0], carry
  - acc <= {fa_sum, acc[WIDTH-1:1]}, so the result bit enters at the MSB and moves toward the LSB
  - a_sh and b_sh shift right by 1; carry <= fa_cout; cnt <= cnt+1
- SHIFT exit: on the cycle where cnt==WIDTH-1, after the update above:
  - sum <= final acc, cout <= fa_cout
  - next state DONE
- DONE: done=1 for exactly this cycle; next state IDLE unconditionally.
- start is ignored in SHIFT and DONE. There is no queueing; the request is dropped.
- a/b/cin may change freely after the accepting edge without affecting the result.
- sum/cout change only on the SHIFT→DONE edge and hold through later operations until the next completion.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); it is exact and never overflows.
- cnt width is $clog2(WIDTH+1). WIDTH=1 is legal: exactly one SHIFT cycle.

## Timing
- Start accepted at rising edge E0.
- SHIFT occupies edges E1..E_WIDTH.
- sum/cout update and done rise at E_WIDTH; done falls at E_WIDTH+1, when the block returns to IDLE.
- Latency from accepting edge to done: WIDTH cycles. Throughput: one addition per WIDTH+2 cycles.
- A start held high continuously is accepted again at E_WIDTH+2.
- busy rises at E0 and falls at E_WIDTH+1.
- Reset values, applied immediately on rst_n low:
  - state=IDLE, busy=0, done=0, sum=0, cout=0
  - a_sh=0, b_sh=0, carry=0, cnt=0, acc=0
- Reset mid-operation aborts the addition with no done pulse; sum/cout return to 0.

## Structure
- Shared package `adder_pkg` holds:
  - state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - the default WIDTH constant
- Sub-module: one instance of the existing `fulladdbhav` cell (ports a, b, cin, sum, cout), purely combinational.
- Control FSM, shift registers, counter and result registers stay in serial_adder.

## Test plan
- WIDTH=8: a=8'h00, b=8'h00, cin=0 -> done exactly 8 cycles after accept; sum=8'h00, cout=0.
- WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Follow with a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0; sum holds 8'h00 until the second done.
- WIDTH=8: a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; busy high for exactly 9 cycles.
- Start pulsed again 3 cycles after accept with different operands -> ignored; result and done timing are unchanged from the first request.
- rst_n low at cnt=4 of a running add -> busy, done, sum and cout are 0 immediately; no done pulse. A fresh start after release completes correctly.
- WIDTH=1: all 8 {a,b,cin} combinations -> {cout,sum} matches the full-adder truth table; done 1 cycle after each accept.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding and default width for the serial adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fulladdbhav.sv
// rtl/fulladdbhav.sv - combinational single-bit full adder cell
module fulladdbhav (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder around one fulladdbhav cell
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_sum, fa_cout;
    logic             load, step, last;

    fulladdbhav u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result bits enter at the MSB so after WIDTH steps bit 0 holds the first sum bit.
    always_comb begin
        acc_nxt            = acc >> 1;
        acc_nxt[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
        end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_cout;
            cnt   <= cnt + CW'(1);
            acc   <= acc_nxt;
            if (last) begin
                sum  <= acc_nxt;
                cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy1, done1;
    logic [0:0] sum1;
    logic       cout1;

    int vec_cnt  = 0;
    int miscmp   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vec_cnt++;
        if (obs !== want) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Called on a falling edge; start is sampled at the next rising edge (E0).
    task automatic add8(input logic [7:0] a_in, input logic [7:0] b_in, input logic c_in,
                        input logic [7:0] want_sum, input logic want_cout, input int poke_at,
                        input logic [7:0] prev_sum, input logic prev_cout);
        a8     = a_in;
        b8     = b_in;
        cin8   = c_in;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8     = ~a_in;
        b8     = a_in;
        cin8   = ~c_in;
        check("w8_busy_after_accept", busy8, 1);
        check("w8_done_after_accept", done8, 0);
        for (int i = 1; i <= 8; i++) begin
            if (i == poke_at) begin
                start8 = 1'b1;
                a8     = 8'hFF;
                b8     = 8'hFF;
                cin8   = 1'b1;
            end
            @(negedge clk);
            start8 = 1'b0;
            if (i < 8) begin
                check("w8_done_early", done8, 0);
                check("w8_busy_shift", busy8, 1);
                check("w8_sum_hold", sum8, prev_sum);
                check("w8_cout_hold", cout8, prev_cout);
            end else begin
                check("w8_done_pulse", done8, 1);
                check("w8_busy_done", busy8, 1);
                check("w8_sum", sum8, want_sum);
                check("w8_cout", cout8, want_cout);
            end
        end
        @(negedge clk);
        check("w8_done_fall", done8, 0);
        check("w8_busy_fall", busy8, 0);
        check("w8_sum_after", sum8, want_sum);
        check("w8_cout_after", cout8, want_cout);
    endtask

    logic [1:0] fa_tab [8];
    logic [2:0] v;

    initial begin
        fa_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_sum8", sum8, 8'h00);
        check("rst_cout8", cout8, 0);
        check("rst_busy1", busy1, 0);
        check("rst_sum1", {cout1, sum1}, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        add8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0);
        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0);
        add8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 0, 8'h00, 1'b1);
        add8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0, 8'h4B, 1'b0);
        add8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3, 8'h00, 1'b1);

        // Abort a running add after E4 (cnt=4).
        a8 = 8'h55; b8 = 8'h66; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy8, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        check("mid_rst_sum", sum8, 8'h00);
        check("mid_rst_cout", cout8, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_done", done8, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy8, 0);
        add8(8'h55, 8'h66, 1'b0, 8'hBB, 1'b0, 0, 8'h00, 1'b0);

        for (int k = 0; k < 8; k++) begin
            v      = 3'(k);
            a1     = v[2];
            b1     = v[1];
            cin1   = v[0];
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check("w1_busy_shift", busy1, 1);
            check("w1_done_early", done1, 0);
            @(negedge clk);
            check("w1_done_pulse", done1, 1);
            check("w1_result", {cout1, sum1}, fa_tab[k]);
            @(negedge clk);
            check("w1_done_fall", done1, 0);
            check("w1_busy_fall", busy1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
